// File: rtl/snpu_pkg.sv
// -----------------------------------------------------------------------------
// snpu_pkg
//  Shared definitions for the SNPU random-bank readout path: default bank
//  geometry (used by both the bank top and the harvester) and the harvester
//  state encoding.
// -----------------------------------------------------------------------------
package snpu_pkg;

   // Default bank geometry, shared with the funky_rnd bank top.
   localparam int SNPU_N_SRC = 32;
   localparam int SNPU_W     = 16;

   // Harvester sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD,
      ST_CAPTURE,
      ST_DRAIN,
      ST_FAULT
   } harv_state_t;

endpackage : snpu_pkg

// File: rtl/vn_compress.sv
// -----------------------------------------------------------------------------
// vn_compress
//  Combinational von Neumann debiaser for one bank word.
//  Pairs (word[2k], word[2k+1]) are visited with k ascending; an unequal pair
//  emits word[2k], an equal pair (00/11) emits nothing. Emitted bits are packed
//  from bit 0 upward, unused upper bits are zero. With raw=1 the whole word is
//  passed through and count=W.
//
//  Ports
//   word   in   W      sampled bank word
//   raw    in   1      1 = bypass whitening
//   bits   out  W      packed output bits, bits[0] = first emitted
//   count  out  CNT_W  number of valid bits in bits (0..W)
// -----------------------------------------------------------------------------
module vn_compress #(
   parameter int W     = 16,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     word,
   input  logic             raw,
   output logic [W-1:0]     bits,
   output logic [CNT_W-1:0] count
);

   always_comb begin
      int n;
      // NOTE: every output gets a default before any branch; a path that leaves
      // an output unassigned would infer a latch.
      bits = '0;
      n    = 0;
      if (raw) begin
         bits = word;
         n    = W;
      end else begin
         for (int k = 0; k < W / 2; k++) begin
            if (word[2*k] != word[2*k+1]) begin
               bits = bits | (W'(word[2*k]) << n);
               n++;
            end
         end
      end
      count = CNT_W'(n);
   end

endmodule : vn_compress

// File: rtl/rnd_harvester.sv
// -----------------------------------------------------------------------------
// rnd_harvester
//  Consumer end of the SNPU random-bank readout interface. Sequences the bank
//  (run unfrozen, freeze, capture), walks the generator address, debiases each
//  sample (or passes it raw) and packs the bits into bytes on a valid/ready
//  stream. A repetition test halts harvesting when the bank output sticks.
//
//  Ports
//   clk         in   1       clock
//   rst         in   1       asynchronous active-high reset
//   en          in   1       keep harvesting; sampled at IDLE exit and end of DRAIN
//   raw_mode    in   1       1 = bypass whitening (sampled in CAPTURE)
//   clr_fault   in   1       leave FAULT, return to IDLE
//   rnd_freeze  out  1       freeze to bank, 1 = hold generators
//   rnd_addr    out  ADDR_W  generator select, wraps modulo N_SRC
//   rnd_data    in   W       selected generator word
//   byte_data   out  8       output byte, LSB = oldest harvested bit
//   byte_valid  out  1       byte_data holds a byte
//   byte_ready  in   1       consumer accepts
//   fault       out  1       sticky repetition-test failure
//   busy        out  1       state is not IDLE or FAULT
// -----------------------------------------------------------------------------
module rnd_harvester
   import snpu_pkg::*;
#(
   parameter int N_SRC      = SNPU_N_SRC,
   parameter int ADDR_W     = $clog2(N_SRC),
   parameter int W          = SNPU_W,
   parameter int SETTLE_CYC = 4,
   parameter int HOLD_CYC   = 2,
   parameter int REP_LIMIT  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              raw_mode,
   input  logic              clr_fault,
   output logic              rnd_freeze,
   output logic [ADDR_W-1:0] rnd_addr,
   input  logic [W-1:0]      rnd_data,
   output logic [7:0]        byte_data,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              fault,
   output logic              busy
);

   localparam int ACC_W   = W + 8;
   localparam int CNT_W   = $clog2(W + 8);
   localparam int VN_W    = $clog2(W + 1);
   localparam int TMR_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int REP_W   = $clog2(REP_LIMIT + 1);

   harv_state_t      state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     prev_q;
   logic [REP_W-1:0] rep_q;
   logic [REP_W-1:0] rep_next;
   logic             rep_hit;
   logic             do_capture;
   logic             pop;
   logic [W-1:0]     vn_bits;
   logic [VN_W-1:0]  vn_count;

   vn_compress #(
      .W     (W),
      .CNT_W (VN_W)
   ) u_vn (
      .word  (rnd_data),
      .raw   (raw_mode),
      .bits  (vn_bits),
      .count (vn_count)
   );

   // Byte stream view of the accumulator.
   assign byte_valid = (cnt_q >= CNT_W'(8));
   assign byte_data  = acc_q[7:0];
   assign pop        = byte_valid & byte_ready;

   assign fault = (state_q == ST_FAULT);
   assign busy  = (state_q != ST_IDLE) && (state_q != ST_FAULT);

   // Repetition count this capture would produce; reaching the limit trips.
   assign rep_next = (rnd_data == prev_q) ? rep_q + REP_W'(1) : REP_W'(1);
   assign rep_hit  = (rep_next == REP_W'(REP_LIMIT));

   // State and phase timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments so
         // every register samples the pre-edge values of the others.
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      rnd_freeze = 1'b0;
      do_capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_SETTLE;
               timer_d = '0;
            end
         end
         ST_SETTLE: begin
            if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
               state_d = ST_HOLD;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_HOLD: begin
            rnd_freeze = 1'b1;
            if (timer_q == TMR_W'(HOLD_CYC - 1)) begin
               state_d = ST_CAPTURE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_CAPTURE: begin
            rnd_freeze = 1'b1;
            do_capture = 1'b1;
            state_d    = rep_hit ? ST_FAULT : ST_DRAIN;
         end
         ST_DRAIN: begin
            // The next sample may only start once whole bytes are gone, which
            // keeps cnt below 8 at every capture and the accumulator in range.
            if (cnt_q < CNT_W'(8)) begin
               state_d = en ? ST_SETTLE : ST_IDLE;
               timer_d = '0;
            end
         end
         ST_FAULT: begin
            if (clr_fault) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: address walk, accumulator and repetition test.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd_addr <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         prev_q   <= '0;
         rep_q    <= '0;
      end else if (state_q == ST_FAULT) begin
         acc_q <= '0;
         cnt_q <= '0;
         if (clr_fault) rep_q <= '0;
      end else if (do_capture) begin
         rnd_addr <= (rnd_addr == ADDR_W'(N_SRC - 1)) ? '0 : rnd_addr + ADDR_W'(1);
         prev_q   <= rnd_data;
         rep_q    <= rep_next;
         if (rep_hit) begin
            // A stuck sample is never emitted; the stream is flushed on entry.
            acc_q <= '0;
            cnt_q <= '0;
         end else begin
            acc_q <= acc_q | (ACC_W'(vn_bits) << cnt_q);
            cnt_q <= cnt_q + CNT_W'(vn_count);
         end
      end else if (pop) begin
         acc_q <= acc_q >> 8;
         cnt_q <= cnt_q - CNT_W'(8);
      end
   end

endmodule : rnd_harvester
